rtc_read_sequencer: RTL and testbench
=====================================

# rtc_read_sequencer

Reads the RTC time-of-day registers (seconds 0x21, minutes 0x22, hours 0x23) over the Intel-mode multiplexed address/data bus of the V3023. It is the read-side counterpart to the RTC programming sequencer.
- On a start request it runs three address-write/data-read transaction pairs with the same control-line timing style.
- It captures the returned BCD bytes and presents them together as one coherent time snapshot to the display/controller logic.
- It shares the RTC bus with the programming sequencer. The top level arbitrates; only one sequencer is active at a time.

## Interface
Parameters:
- T_SETUP, default 2: cycles from CS/AD/address valid to strobe falling edge (1..15).
- T_PULSE, default 4: cycles WR or RD is held low (1..15).
- T_HOLD, default 2: cycles after the strobe rises before AD changes or CS is released (1..15).

Ports (clock and reset first):
- Clock  in  1  system clock, single clock domain.
- Reset  in  1  synchronous, active-high reset.
- Inicie  in  1  start request; sampled only in IDLE.
- BusIn  in  8  RTC data bus, input side.
- BusOut  out  8  RTC bus, driven value during the address phase.
- BusOE  out  1  1 = block drives the bus (address phase only).
- ADo, CSo, WRo, RDo  out  1 each  RTC control lines. ADo: 0 = address, 1 = data. CSo, WRo and RDo are active low.
- Segundos, Minutos, Horas  out  8 each  captured BCD time values.
- Ready  out  1  one-cycle pulse; snapshot is valid.
- ErrBCD  out  1  valid with Ready; 1 if any captured nibble is greater than 9.
- Busy  out  1  high in every state except IDLE.

## Operation
- All outputs are registered.
- Reset values:
  - CSo, WRo, RDo and ADo are 1.
  - BusOE is 0 and BusOut is 0x00.
  - Segundos, Minutos and Horas are 0x00.
  - Ready, ErrBCD and Busy are 0.
  - State is IDLE and the index is 0.
- States: IDLE, A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD, GAP, DONE.
- Phase counter: 4 bits. It loads at phase entry and advances to the next phase when it reaches the phase's parameter length.
- Register index: 2 bits, values 0..2. It maps to addresses 0x21, 0x22, 0x23.
- IDLE: when Inicie=1, go to A_SETUP with index 0. Otherwise stay in IDLE.
- A_SETUP, T_SETUP cycles: CSo=0, ADo=0, BusOE=1, BusOut=address.
- A_PULSE, T_PULSE cycles: as A_SETUP, plus WRo=0.
- A_HOLD, T_HOLD cycles: WRo=1; CSo, ADo, BusOE and BusOut are unchanged.
- D_SETUP, T_SETUP cycles: ADo=1, BusOE=0, CSo=0.
- D_PULSE, T_PULSE cycles: RDo=0. BusIn is captured into the shadow register [index] at the clock edge that ends the last D_PULSE cycle.
- D_HOLD, T_HOLD cycles: RDo=1, CSo=0.
- After D_HOLD:
  - If index < 2: go to GAP for 1 cycle, with all control lines inactive and BusOE=0. Then increment the index and go to A_SETUP.
  - If index = 2: go to DONE.
- DONE, 1 cycle:
  - Ready=1.
  - Segundos, Minutos and Horas are loaded from the shadow registers on the edge entering DONE.
  - ErrBCD is computed over all six nibbles.
  - Next state is IDLE.
- Outputs never show a partially updated snapshot; the shadow registers are committed only in DONE.
- Inicie while Busy=1 (including in DONE) is ignored and not queued.
- Reset at any point: all outputs return to their reset values at the next edge, including clearing the captured time. No bus cycle is completed.
- WRo and RDo are never low in the same cycle.
- BusOE=1 only while ADo=0 and CSo=0.

## Timing
- Edge 0 samples Inicie=1 in IDLE. The first bus activity (CSo=0, ADo=0, BusOE=1, BusOut=0x21) is visible in cycle 1.
- One register transaction is 2·(T_SETUP+T_PULSE+T_HOLD) cycles: 16 with defaults.
- Defaults, cycle by cycle:
  - Register 0 occupies cycles 1–16 and GAP is cycle 17.
  - Register 1 occupies cycles 18–33 and GAP is cycle 34.
  - Register 2 occupies cycles 35–50 and DONE is cycle 51.
- General latency: Ready in cycle 6·(T_SETUP+T_PULSE+T_HOLD)+3.
- Busy is high in cycles 1..51 with defaults.
- A new Inicie is accepted no earlier than the edge ending cycle 52, i.e. in IDLE.
- With defaults, within each transaction:
  - WRo is low in cycles 3–6 (transaction-relative).
  - ADo rises at cycle 9.
  - RDo is low in cycles 11–14, with sampling at the edge ending cycle 14.

## Test plan
- Reset check: hold Reset for 3 cycles. Then CSo=WRo=RDo=ADo=1, BusOE=0, outputs 0x00, Ready=0, Busy=0.
- Nominal read: model the RTC returning 0x45, 0x30, 0x12 for addresses 0x21, 0x22, 0x23. Pulse Inicie. Expected:
  - Ready in cycle 51.
  - Segundos=0x45, Minutos=0x30, Horas=0x12, ErrBCD=0.
  - BusOut shows 0x21, 0x22, 0x23 in the respective address phases.
- Protocol checker over the full sequence:
  - Strobe widths are exactly 4 cycles.
  - No WR/RD overlap.
  - BusOE=0 whenever ADo=1.
  - CSo=1 in both GAP cycles.
  - Capture occurs on the last RD-low edge: change BusIn one cycle after that edge and verify the captured value is unchanged.
- BCD error: model returns 0x5A for minutes. Expected ErrBCD=1 with Ready, and Minutos=0x5A.
- Ignored start: hold Inicie high continuously. Expected one sequence per 52 cycles, with Ready spaced 52 cycles apart. An Inicie pulse at cycle 20 has no effect.
- Reset mid-operation:
  - Complete one read with 0x45, 0x30, 0x12. Start a second read with different model values and assert Reset in cycle 25.
  - Expected next cycle: all outputs at reset values, Segundos=0x00, no Ready.
  - A subsequent Inicie then runs a clean full sequence.

Source files
------------

// File: rtl/rtc_read_sequencer.sv
// -----------------------------------------------------------------------------
// rtc_read_sequencer
//
// Reads the V3023 RTC time-of-day registers (seconds 0x21, minutes 0x22,
// hours 0x23) over the Intel-mode multiplexed address/data bus.
// Each register is read with one address-write / data-read pair.
// The three captured BCD bytes are then presented together as one coherent
// snapshot.
//
// Parameters
//   T_SETUP  cycles from CS/AD/address valid to strobe falling edge (1..15)
//   T_PULSE  cycles WR or RD is held low (1..15)
//   T_HOLD   cycles after strobe rise before AD changes / CS release (1..15)
//
// Ports
//   Clock                  system clock
//   Reset                  synchronous, active-high reset
//   Inicie                 start request, honoured only in IDLE
//   BusIn[7:0]             RTC data bus, input side
//   BusOut[7:0]            RTC bus drive value (address phase)
//   BusOE                  1 = this block drives the bus
//   ADo, CSo, WRo, RDo     RTC control lines (ADo 0 = address; CS/WR/RD low)
//   Segundos/Minutos/Horas captured BCD time snapshot
//   Ready                  one-cycle pulse, snapshot valid
//   ErrBCD                 valid with Ready, some captured nibble > 9
//   Busy                   high in every state except IDLE
//
// All outputs are registered.  The output register is loaded from a decode
// of the *next* state, so the pins change in the same cycle the FSM enters
// a state.
// -----------------------------------------------------------------------------
module rtc_read_sequencer #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Inicie,
    input  logic [7:0] BusIn,
    output logic [7:0] BusOut,
    output logic       BusOE,
    output logic       ADo,
    output logic       CSo,
    output logic       WRo,
    output logic       RDo,
    output logic [7:0] Segundos,
    output logic [7:0] Minutos,
    output logic [7:0] Horas,
    output logic       Ready,
    output logic       ErrBCD,
    output logic       Busy
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_A_SETUP = 4'd1,
        ST_A_PULSE = 4'd2,
        ST_A_HOLD  = 4'd3,
        ST_D_SETUP = 4'd4,
        ST_D_PULSE = 4'd5,
        ST_D_HOLD  = 4'd6,
        ST_GAP     = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

    // Phase lengths in the width of the phase counter.
    localparam logic [3:0] SETUP_LEN = 4'(T_SETUP);
    localparam logic [3:0] PULSE_LEN = 4'(T_PULSE);
    localparam logic [3:0] HOLD_LEN  = 4'(T_HOLD);

    localparam logic [1:0] LAST_IDX  = 2'd2;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Register index to RTC address.
    function automatic logic [7:0] reg_addr(input logic [1:0] idx);
        logic [7:0] addr;
        case (idx)
            2'd0:    addr = 8'h21;
            2'd1:    addr = 8'h22;
            2'd2:    addr = 8'h23;
            default: addr = 8'h21;
        endcase
        return addr;
    endfunction

    // 1 when either nibble of a byte is not a legal BCD digit.
    function automatic logic bcd_invalid(input logic [7:0] b);
        return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
    endfunction

    // -------------------------------------------------------------------------
    // State, phase counter, register index
    // -------------------------------------------------------------------------
    state_t     state_r;
    state_t     state_next_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_next_s;
    logic [1:0] idx_r;
    logic [1:0] idx_next_s;

    // Shadow registers, filled one per transaction and committed in DONE.
    logic [7:0] shd_sec_r;
    logic [7:0] shd_min_r;
    logic [7:0] shd_hr_r;

    // Next-cycle values for the registered outputs.
    logic [7:0] bus_out_s;
    logic       bus_oe_s;
    logic       ad_s;
    logic       cs_s;
    logic       wr_s;
    logic       rd_s;
    logic       ready_s;
    logic       busy_s;
    logic       err_s;
    logic       capture_s;
    logic       commit_s;

    // Output registers.
    logic [7:0] bus_out_r;
    logic       bus_oe_r;
    logic       ad_r;
    logic       cs_r;
    logic       wr_r;
    logic       rd_r;
    logic [7:0] seg_r;
    logic [7:0] min_r;
    logic [7:0] hr_r;
    logic       ready_r;
    logic       err_r;
    logic       busy_r;

    // State register with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= 2'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Next-state logic.  The counter is 1 in the first cycle of each phase,
    // and the phase ends in the cycle where the counter equals its length.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        idx_next_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (Inicie) begin
                    state_next_s = ST_A_SETUP;
                    cnt_next_s   = 4'd1;
                    idx_next_s   = 2'd0;
                end else begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 4'd0;
                end
            end
            ST_A_SETUP: begin
                if (cnt_r == SETUP_LEN) begin
                    state_next_s = ST_A_PULSE;
                    cnt_next_s   = 4'd1;
                end else begin
                    cnt_next_s   = cnt_r + 4'd1;
                end
            end
            ST_A_PULSE: begin
                if (cnt_r == PULSE_LEN) begin
                    state_next_s = ST_A_HOLD;
                    cnt_next_s   = 4'd1;
                end else begin
                    cnt_next_s   = cnt_r + 4'd1;
                end
            end
            ST_A_HOLD: begin
                if (cnt_r == HOLD_LEN) begin
                    state_next_s = ST_D_SETUP;
                    cnt_next_s   = 4'd1;
                end else begin
                    cnt_next_s   = cnt_r + 4'd1;
                end
            end
            ST_D_SETUP: begin
                if (cnt_r == SETUP_LEN) begin
                    state_next_s = ST_D_PULSE;
                    cnt_next_s   = 4'd1;
                end else begin
                    cnt_next_s   = cnt_r + 4'd1;
                end
            end
            ST_D_PULSE: begin
                if (cnt_r == PULSE_LEN) begin
                    state_next_s = ST_D_HOLD;
                    cnt_next_s   = 4'd1;
                end else begin
                    cnt_next_s   = cnt_r + 4'd1;
                end
            end
            ST_D_HOLD: begin
                if (cnt_r == HOLD_LEN) begin
                    cnt_next_s = 4'd1;
                    if (idx_r == LAST_IDX) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_GAP;
                    end
                end else begin
                    cnt_next_s = cnt_r + 4'd1;
                end
            end
            ST_GAP: begin
                // The index advances here so the next address phase already
                // shows the following register address.
                state_next_s = ST_A_SETUP;
                cnt_next_s   = 4'd1;
                idx_next_s   = idx_r + 2'd1;
            end
            ST_DONE: begin
                // Inicie is deliberately not looked at here: no queuing.
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
                idx_next_s   = 2'd0;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
                idx_next_s   = 2'd0;
            end
        endcase
    end

    // Output decode of the next state.  This feeds the output register.
    always_comb begin
        bus_out_s = 8'h00;
        bus_oe_s  = 1'b0;
        ad_s      = 1'b1;
        cs_s      = 1'b1;
        wr_s      = 1'b1;
        rd_s      = 1'b1;
        ready_s   = 1'b0;
        busy_s    = 1'b1;
        case (state_next_s)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_A_SETUP: begin
                cs_s      = 1'b0;
                ad_s      = 1'b0;
                bus_oe_s  = 1'b1;
                bus_out_s = reg_addr(idx_next_s);
            end
            ST_A_PULSE: begin
                cs_s      = 1'b0;
                ad_s      = 1'b0;
                bus_oe_s  = 1'b1;
                bus_out_s = reg_addr(idx_next_s);
                wr_s      = 1'b0;
            end
            ST_A_HOLD: begin
                cs_s      = 1'b0;
                ad_s      = 1'b0;
                bus_oe_s  = 1'b1;
                bus_out_s = reg_addr(idx_next_s);
            end
            ST_D_SETUP: begin
                cs_s = 1'b0;
            end
            ST_D_PULSE: begin
                cs_s = 1'b0;
                rd_s = 1'b0;
            end
            ST_D_HOLD: begin
                cs_s = 1'b0;
            end
            ST_GAP: begin
                // Every control line is idle and the bus is released.
                busy_s = 1'b1;
            end
            ST_DONE: begin
                ready_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Capture strobe is on the edge that ends the last RD-low cycle.
    // Commit is on the edge that enters DONE.
    always_comb begin
        capture_s = (state_r == ST_D_PULSE) && (cnt_r == PULSE_LEN);
        commit_s  = (state_next_s == ST_DONE);
        if (ready_s) begin
            err_s = bcd_invalid(shd_sec_r) || bcd_invalid(shd_min_r) ||
                    bcd_invalid(shd_hr_r);
        end else begin
            err_s = 1'b0;
        end
    end

    // Shadow capture of the byte returned by the RTC for the current index.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            shd_sec_r <= 8'h00;
            shd_min_r <= 8'h00;
            shd_hr_r  <= 8'h00;
        end else if (capture_s) begin
            case (idx_r)
                2'd0:    shd_sec_r <= BusIn;
                2'd1:    shd_min_r <= BusIn;
                2'd2:    shd_hr_r  <= BusIn;
                default: shd_sec_r <= shd_sec_r;
            endcase
        end
    end

    // Output register: control lines every cycle, snapshot only on commit.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bus_out_r <= 8'h00;
            bus_oe_r  <= 1'b0;
            ad_r      <= 1'b1;
            cs_r      <= 1'b1;
            wr_r      <= 1'b1;
            rd_r      <= 1'b1;
            seg_r     <= 8'h00;
            min_r     <= 8'h00;
            hr_r      <= 8'h00;
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            bus_out_r <= bus_out_s;
            bus_oe_r  <= bus_oe_s;
            ad_r      <= ad_s;
            cs_r      <= cs_s;
            wr_r      <= wr_s;
            rd_r      <= rd_s;
            ready_r   <= ready_s;
            err_r     <= err_s;
            busy_r    <= busy_s;
            if (commit_s) begin
                // The last shadow byte was captured during D_PULSE, so all
                // three are stable by the time DONE is entered.
                seg_r <= shd_sec_r;
                min_r <= shd_min_r;
                hr_r  <= shd_hr_r;
            end
        end
    end

    assign BusOut   = bus_out_r;
    assign BusOE    = bus_oe_r;
    assign ADo      = ad_r;
    assign CSo      = cs_r;
    assign WRo      = wr_r;
    assign RDo      = rd_r;
    assign Segundos = seg_r;
    assign Minutos  = min_r;
    assign Horas    = hr_r;
    assign Ready    = ready_r;
    assign ErrBCD   = err_r;
    assign Busy     = busy_r;

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rtc_read_sequencer
//
// Directed bench for rtc_read_sequencer with default timing (2/4/2).
// A small RTC bus model returns a programmable byte per address.  The byte is
// presented only in the fourth consecutive RD-low cycle; every other cycle it
// shows 0xEE.  The expected cycle table below is written out by hand from the
// documented default timing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rtc_read_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Inicie = 1'b0;
    logic [7:0] BusIn;
    logic [7:0] BusOut;
    logic       BusOE;
    logic       ADo;
    logic       CSo;
    logic       WRo;
    logic       RDo;
    logic [7:0] Segundos;
    logic [7:0] Minutos;
    logic [7:0] Horas;
    logic       Ready;
    logic       ErrBCD;
    logic       Busy;

    int vectors = 0;
    int miscompares = 0;

    // RTC model contents
    logic [7:0] mem_sec = 8'h45;
    logic [7:0] mem_min = 8'h30;
    logic [7:0] mem_hr  = 8'h12;
    logic [7:0] rtc_addr = 8'h00;
    int         rd_run = 0;

    rtc_read_sequencer #(.T_SETUP(2), .T_PULSE(4), .T_HOLD(2)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Inicie   (Inicie),
        .BusIn    (BusIn),
        .BusOut   (BusOut),
        .BusOE    (BusOE),
        .ADo      (ADo),
        .CSo      (CSo),
        .WRo      (WRo),
        .RDo      (RDo),
        .Segundos (Segundos),
        .Minutos  (Minutos),
        .Horas    (Horas),
        .Ready    (Ready),
        .ErrBCD   (ErrBCD),
        .Busy     (Busy)
    );

    always #5 Clock = ~Clock;

    // RTC model: latch the address under WR, count RD-low cycles.
    always @(posedge Clock) begin
        if (!CSo && !ADo && !WRo) rtc_addr <= BusOut;
        if (!RDo) rd_run <= rd_run + 1;
        else      rd_run <= 0;
    end

    assign BusIn = (!RDo && rd_run == 3) ?
                   ((rtc_addr == 8'h21) ? mem_sec :
                    (rtc_addr == 8'h22) ? mem_min :
                    (rtc_addr == 8'h23) ? mem_hr  : 8'hEE) : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // All outputs at their reset / idle values, snapshot cleared.
    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_cs"},    32'(CSo), 32'h1);
        chk({pfx, "_wr"},    32'(WRo), 32'h1);
        chk({pfx, "_rd"},    32'(RDo), 32'h1);
        chk({pfx, "_ad"},    32'(ADo), 32'h1);
        chk({pfx, "_oe"},    32'(BusOE), 32'h0);
        chk({pfx, "_bus"},   32'(BusOut), 32'h0);
        chk({pfx, "_time"},  32'({Segundos, Minutos, Horas}), 32'h0);
        chk({pfx, "_ready"}, 32'(Ready), 32'h0);
        chk({pfx, "_err"},   32'(ErrBCD), 32'h0);
        chk({pfx, "_busy"},  32'(Busy), 32'h0);
    endtask

    // One full read from IDLE.  Called just after a clock edge.
    // pulse_at: cycle in which a one-cycle Inicie is driven (0 = none).
    task automatic run_seq(input string pfx,
                           input logic [7:0] es, input logic [7:0] em,
                           input logic [7:0] eh, input logic ee,
                           input logic [23:0] prev, input int pulse_at);
        int ready_cyc = 0;
        int ready_cnt = 0;
        int busy_cnt = 0;
        int bad_cs = 0, bad_ad = 0, bad_wr = 0, bad_rd = 0, bad_oe = 0, bad_bus = 0;
        int bad_ov = 0, bad_oead = 0;
        logic e_cs, e_ad, e_wr, e_rd, e_oe;
        logic [7:0] e_bus;
        int t, rel;
        Inicie = 1'b1;
        tick();                       // edge 0
        Inicie = 1'b0;
        for (int c = 1; c <= 53; c++) begin
            e_cs = 1'b1; e_ad = 1'b1; e_wr = 1'b1; e_rd = 1'b1; e_oe = 1'b0; e_bus = 8'h00;
            t = 0; rel = 0;
            if (c <= 50 && c != 17 && c != 34) begin
                t   = (c - 1) / 17;
                rel = c - 17 * t;
                e_cs  = 1'b0;
                e_ad  = (rel >= 9);
                e_wr  = !(rel >= 3 && rel <= 6);
                e_rd  = !(rel >= 11 && rel <= 14);
                e_oe  = (rel <= 8);
                e_bus = 8'h21 + t[7:0];
            end
            if (CSo !== e_cs) bad_cs++;
            if (rel != 0 && ADo !== e_ad) bad_ad++;
            if (WRo !== e_wr) bad_wr++;
            if (RDo !== e_rd) bad_rd++;
            if (BusOE !== e_oe) bad_oe++;
            if (e_oe && BusOut !== e_bus) bad_bus++;
            if (!WRo && !RDo) bad_ov++;
            if (ADo && BusOE) bad_oead++;
            if (Busy) busy_cnt++;
            if (Ready) begin
                ready_cnt++;
                if (ready_cyc == 0) ready_cyc = c;
            end
            if (c == 50) chk({pfx, "_no_partial"}, 32'({Segundos, Minutos, Horas}), 32'(prev));
            if (c == 51) begin
                chk({pfx, "_seg"}, 32'(Segundos), 32'(es));
                chk({pfx, "_min"}, 32'(Minutos),  32'(em));
                chk({pfx, "_hr"},  32'(Horas),    32'(eh));
                chk({pfx, "_err"}, 32'(ErrBCD),   32'(ee));
            end
            if (c == 53) chk({pfx, "_idle_after"}, 32'(Busy), 32'h0);
            Inicie = (c + 1 == pulse_at);
            tick();
        end
        Inicie = 1'b0;
        chk({pfx, "_ready_cycle"}, 32'(ready_cyc), 32'd51);
        chk({pfx, "_ready_count"}, 32'(ready_cnt), 32'd1);
        chk({pfx, "_busy_cycles"}, 32'(busy_cnt), 32'd51);
        chk({pfx, "_cs_pattern"},  32'(bad_cs), 32'd0);
        chk({pfx, "_ad_pattern"},  32'(bad_ad), 32'd0);
        chk({pfx, "_wr_pattern"},  32'(bad_wr), 32'd0);
        chk({pfx, "_rd_pattern"},  32'(bad_rd), 32'd0);
        chk({pfx, "_oe_pattern"},  32'(bad_oe), 32'd0);
        chk({pfx, "_addr_bus"},    32'(bad_bus), 32'd0);
        chk({pfx, "_wr_rd_overlap"}, 32'(bad_ov), 32'd0);
        chk({pfx, "_oe_in_data"},  32'(bad_oead), 32'd0);
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r1, r2, r3, nr, waited;

        // Reset for 3 cycles.
        Reset  = 1'b1;
        Inicie = 1'b0;
        repeat (3) tick();
        Reset = 1'b0;
        chk_reset_outputs("reset");

        // Nominal read, with an ignored Inicie pulse at cycle 20.
        mem_sec = 8'h45; mem_min = 8'h30; mem_hr = 8'h12;
        run_seq("nominal", 8'h45, 8'h30, 8'h12, 1'b0, 24'h000000, 20);

        // BCD error in the minutes register.
        mem_min = 8'h5A;
        run_seq("bcd", 8'h45, 8'h5A, 8'h12, 1'b1, 24'h453012, 0);

        // Inicie held high: one sequence per 52 cycles.
        mem_min = 8'h30;
        r1 = 0; r2 = 0; r3 = 0; nr = 0;
        Inicie = 1'b1;
        for (int c = 1; c <= 160; c++) begin
            tick();
            if (Ready) begin
                nr++;
                if (nr == 1) r1 = c;
                else if (nr == 2) r2 = c;
                else if (nr == 3) r3 = c;
            end
        end
        Inicie = 1'b0;
        chk("held_ready1", 32'(r1), 32'd51);
        chk("held_ready2", 32'(r2), 32'd103);
        chk("held_ready3", 32'(r3), 32'd155);
        waited = 0;
        while (Busy && waited < 100) begin
            tick();
            waited++;
        end
        chk("held_drain_busy", 32'(Busy), 32'h0);
        chk("held_snapshot", 32'({Segundos, Minutos, Horas}), 32'h453012);

        // Complete read, then reset in the middle of the next one.
        run_seq("pre_reset", 8'h45, 8'h30, 8'h12, 1'b0, 24'h453012, 0);
        mem_sec = 8'h11; mem_min = 8'h22; mem_hr = 8'h33;
        Inicie = 1'b1;
        tick();                       // edge 0, now cycle 1
        Inicie = 1'b0;
        for (int c = 1; c < 25; c++) tick();   // now cycle 25
        chk("midrst_busy_before", 32'(Busy), 32'h1);
        chk("midrst_seg_before",  32'(Segundos), 32'h45);
        Reset = 1'b1;
        tick();                       // cycle 26
        Reset = 1'b0;
        chk_reset_outputs("midrst");
        nr = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (Ready || Busy) nr++;
        end
        chk("midrst_quiet", 32'(nr), 32'd0);
        run_seq("after_rst", 8'h11, 8'h22, 8'h33, 1'b0, 24'h000000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
